// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU datapath types for the register file write queue
package cpu_types_pkg;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  regbits_t;

    typedef struct packed {
        regbits_t sel;
        word_t    dat;
    } wq_entry_t;

    localparam int WQ_DEPTH_DEFAULT = 4;

endpackage

// File: rtl/wq_fifo.sv
// rtl/wq_fifo.sv - in-order storage/pointer/occupancy FIFO of write-queue entries
module wq_fifo
    import cpu_types_pkg::*;
#(
    parameter int DEPTH = WQ_DEPTH_DEFAULT
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          push_i,
    input  wq_entry_t                     push_entry_i,
    input  logic                          pop_i,
    output wq_entry_t                     head_entry_o,
    output logic                          full_o,
    output logic                          empty_o,
    output logic [$clog2(DEPTH+1)-1:0]    occ_o,
    output logic [$clog2(DEPTH)-1:0]      head_o,
    output wq_entry_t [DEPTH-1:0]         mem_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [CW-1:0] OCC_ONE = CW'(1);

    wq_entry_t [DEPTH-1:0] mem_q;
    logic [PW-1:0]         head_q, head_d;
    logic [PW-1:0]         tail_q, tail_d;
    logic [CW-1:0]         occ_q, occ_d;
    logic                  push_ok;
    logic                  pop_ok;

    assign full_o       = (occ_q == CW'(DEPTH));
    assign empty_o      = (occ_q == '0);
    assign push_ok      = push_i && !full_o;
    assign pop_ok       = pop_i && !empty_o;
    assign head_entry_o = mem_q[head_q];
    assign occ_o        = occ_q;
    assign head_o       = head_q;
    assign mem_o        = mem_q;

    // Next-state for pointers (power-of-two depth wraps naturally) and occupancy
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        if (push_ok) begin
            tail_d = tail_q + PTR_ONE;
        end
        if (pop_ok) begin
            head_d = head_q + PTR_ONE;
        end
        if (push_ok && !pop_ok) begin
            occ_d = occ_q + OCC_ONE;
        end else if (pop_ok && !push_ok) begin
            occ_d = occ_q - OCC_ONE;
        end
    end

    // Pointer and occupancy registers; reset discards all queued entries
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    // Entry storage; contents are only meaningful below occupancy, so no reset
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[tail_q] <= push_entry_i;
        end
    end

endmodule

// File: rtl/regfile_write_queue.sv
// rtl/regfile_write_queue.sv - register file write queue with pending-write scoreboard (optional forwarding: REGFILE_WQ_FWD_EN)
module regfile_write_queue
    import cpu_types_pkg::*;
#(
    parameter int DEPTH = WQ_DEPTH_DEFAULT
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  regbits_t                      req_sel,
    input  word_t                         req_dat,
    input  logic                          drain_en,
    output logic                          rf_wen,
    output regbits_t                      rf_wsel,
    output word_t                         rf_wdat,
    input  regbits_t                      rsel1,
    input  regbits_t                      rsel2,
    output logic                          busy1,
    output logic                          busy2,
    output logic                          fwd1_valid,
    output word_t                         fwd1_dat,
    output logic                          fwd2_valid,
    output word_t                         fwd2_dat,
    output logic [$clog2(DEPTH+1)-1:0]    count
);

    localparam int PW    = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    wq_entry_t             push_entry;
    wq_entry_t             head_entry;
    wq_entry_t [DEPTH-1:0] fifo_mem;
    logic [PW-1:0]         fifo_head;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic [CNT_W-1:0]      occ;
    logic [CNT_W-1:0]      cnt_q [32];
    logic [CNT_W-1:0]      cnt_d [32];

    // Writes to r0 are handshaken but never stored
    assign req_ready  = !full;
    assign push       = req_valid && !full && (req_sel != '0);
    assign pop        = rf_wen;
    assign push_entry = '{sel: req_sel, dat: req_dat};

    assign rf_wen  = !empty && drain_en;
    assign rf_wsel = rf_wen ? head_entry.sel : '0;
    assign rf_wdat = rf_wen ? head_entry.dat : '0;
    assign count   = occ;

    wq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i        (CLK),
        .rst_i        (RST),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .head_entry_o (head_entry),
        .full_o       (full),
        .empty_o      (empty),
        .occ_o        (occ),
        .head_o       (fifo_head),
        .mem_o        (fifo_mem)
    );

    // Pending-write counters: a matching push and pop in one cycle cancel out
    always_comb begin
        cnt_d = cnt_q;
        for (int r = 1; r < 32; r++) begin
            if (push && (req_sel == 5'(r)) && !(pop && (head_entry.sel == 5'(r)))) begin
                cnt_d[r] = cnt_q[r] + CNT_ONE;
            end else if (pop && (head_entry.sel == 5'(r)) && !(push && (req_sel == 5'(r)))) begin
                cnt_d[r] = cnt_q[r] - CNT_ONE;
            end
        end
        cnt_d[0] = '0;
    end

    // Scoreboard registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int r = 0; r < 32; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < 32; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    assign busy1 = (rsel1 != '0) && (cnt_q[rsel1] != '0);
    assign busy2 = (rsel2 != '0) && (cnt_q[rsel2] != '0);

`ifdef REGFILE_WQ_FWD_EN
    word_t         fwd1_hit_dat;
    word_t         fwd2_hit_dat;
    logic [PW-1:0] idx;

    // Walk oldest to youngest over live entries so the youngest match wins
    always_comb begin
        fwd1_hit_dat = '0;
        fwd2_hit_dat = '0;
        idx          = fifo_head;
        for (int i = 0; i < DEPTH; i++) begin
            idx = fifo_head + PW'(i);
            if (CNT_W'(i) < occ) begin
                if (fifo_mem[idx].sel == rsel1) begin
                    fwd1_hit_dat = fifo_mem[idx].dat;
                end
                if (fifo_mem[idx].sel == rsel2) begin
                    fwd2_hit_dat = fifo_mem[idx].dat;
                end
            end
        end
    end

    assign fwd1_valid = busy1;
    assign fwd2_valid = busy2;
    assign fwd1_dat   = busy1 ? fwd1_hit_dat : '0;
    assign fwd2_dat   = busy2 ? fwd2_hit_dat : '0;
`else
    logic unused_fwd;
    assign unused_fwd = ^{fifo_mem, fifo_head};
    assign fwd1_valid = 1'b0;
    assign fwd2_valid = 1'b0;
    assign fwd1_dat   = '0;
    assign fwd2_dat   = '0;
`endif

endmodule

// File: tb/tb_regfile_write_queue.sv
// tb/tb_regfile_write_queue.sv - directed self-checking bench for regfile_write_queue
module tb_regfile_write_queue;
    import cpu_types_pkg::*;

    logic        CLK = 1'b0;
    logic        RST;
    logic        req_valid;
    logic        req_ready;
    regbits_t    req_sel;
    word_t       req_dat;
    logic        drain_en;
    logic        rf_wen;
    regbits_t    rf_wsel;
    word_t       rf_wdat;
    regbits_t    rsel1;
    regbits_t    rsel2;
    logic        busy1;
    logic        busy2;
    logic        fwd1_valid;
    word_t       fwd1_dat;
    logic        fwd2_valid;
    word_t       fwd2_dat;
    logic [2:0]  count;

    int errors = 0;
    int checks = 0;

    regfile_write_queue #(.DEPTH(4)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_sel    (req_sel),
        .req_dat    (req_dat),
        .drain_en   (drain_en),
        .rf_wen     (rf_wen),
        .rf_wsel    (rf_wsel),
        .rf_wdat    (rf_wdat),
        .rsel1      (rsel1),
        .rsel2      (rsel2),
        .busy1      (busy1),
        .busy2      (busy2),
        .fwd1_valid (fwd1_valid),
        .fwd1_dat   (fwd1_dat),
        .fwd2_valid (fwd2_valid),
        .fwd2_dat   (fwd2_dat),
        .count      (count)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs changed here are stable well before the following edge
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input logic [4:0] sel, input logic [31:0] dat);
        req_valid = 1'b1;
        req_sel   = sel;
        req_dat   = dat;
        tick();
        req_valid = 1'b0;
        req_sel   = '0;
        req_dat   = '0;
    endtask

    initial begin
        RST = 1'b1; req_valid = 1'b0; req_sel = '0; req_dat = '0;
        drain_en = 1'b0; rsel1 = '0; rsel2 = '0;
        #12;
        check("rst_count",     32'(count),     32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rf_wen",    32'(rf_wen),    32'd0);
        tick();
        RST = 1'b0;
        tick();

        // Reset mid-drain
        rsel1 = 5'd3;
        push(5'd3, 32'h11);
        push(5'd4, 32'h22);
        #1;
        check("t1_count_pre", 32'(count), 32'd2);
        check("t1_busy_pre",  32'(busy1), 32'd1);
        drain_en = 1'b1;
        #1;
        check("t1_wen_pre",  32'(rf_wen),  32'd1);
        check("t1_wsel_pre", 32'(rf_wsel), 32'd3);
        RST = 1'b1;
        #1;
        check("t1_count",     32'(count),     32'd0);
        check("t1_busy1",     32'(busy1),     32'd0);
        check("t1_rf_wen",    32'(rf_wen),    32'd0);
        check("t1_req_ready", 32'(req_ready), 32'd1);
        tick();
        RST = 1'b0;
        drain_en = 1'b0;
        tick();
        check("t1_wen_after", 32'(rf_wen), 32'd0);

        // Basic ordering
        push(5'd5, 32'hA);
        push(5'd6, 32'hB);
        check("t2_no_wen_hold", 32'(rf_wen), 32'd0);
        drain_en = 1'b1;
        #1;
        check("t2_wen0",  32'(rf_wen),  32'd1);
        check("t2_wsel0", 32'(rf_wsel), 32'd5);
        check("t2_wdat0", rf_wdat,      32'hA);
        tick();
        check("t2_wen1",  32'(rf_wen),  32'd1);
        check("t2_wsel1", 32'(rf_wsel), 32'd6);
        check("t2_wdat1", rf_wdat,      32'hB);
        tick();
        check("t2_wen2",  32'(rf_wen),  32'd0);
        check("t2_wsel2", 32'(rf_wsel), 32'd0);
        check("t2_count", 32'(count),   32'd0);

        // Full
        drain_en = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            push(5'(i), 32'(i));
        end
        check("t3_ready_full", 32'(req_ready), 32'd0);
        check("t3_count_full", 32'(count),     32'd4);
        push(5'd8, 32'h88);
        check("t3_count_5th", 32'(count), 32'd4);
        drain_en = 1'b1;
        #1;
        check("t3_ready_drain_en", 32'(req_ready), 32'd0);
        check("t3_pop_sel1",       32'(rf_wsel),   32'd1);
        tick();
        drain_en = 1'b0;
        check("t3_ready_after", 32'(req_ready), 32'd1);
        check("t3_count_after", 32'(count),     32'd3);
        drain_en = 1'b1;
        for (int i = 2; i <= 4; i++) begin
            #1;
            check("t3_drain_sel", 32'(rf_wsel), 32'(i));
            check("t3_drain_dat", rf_wdat,      32'(i));
            tick();
        end
        check("t3_empty_wen", 32'(rf_wen), 32'd0);
        check("t3_empty_cnt", 32'(count),  32'd0);

        // Scoreboard duplicates and simultaneous push/pop of the same register
        drain_en = 1'b0;
        rsel1 = 5'd7;
        rsel2 = 5'd12;
        push(5'd7, 32'd1);
        push(5'd7, 32'd2);
        check("t4_busy1", 32'(busy1), 32'd1);
        check("t4_busy2", 32'(busy2), 32'd0);
        req_valid = 1'b1; req_sel = 5'd7; req_dat = 32'd3;
        drain_en = 1'b1;
        #1;
        check("t4_sim_wsel", 32'(rf_wsel), 32'd7);
        check("t4_sim_wdat", rf_wdat,      32'd1);
        tick();
        req_valid = 1'b0; req_sel = '0; req_dat = '0;
        check("t4_sim_count", 32'(count), 32'd2);
        check("t4_sim_busy",  32'(busy1), 32'd1);
        check("t4_pop2_dat",  rf_wdat,    32'd2);
        tick();
        check("t4_busy_one_left", 32'(busy1), 32'd1);
        check("t4_pop3_dat",      rf_wdat,    32'd3);
        tick();
        check("t4_busy_clear", 32'(busy1), 32'd0);
        check("t4_count_end",  32'(count), 32'd0);

        // Zero register
        rsel1 = 5'd0;
        req_valid = 1'b1; req_sel = 5'd0; req_dat = 32'hFFFF;
        #1;
        check("t5_ready", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        check("t5_count", 32'(count),  32'd0);
        check("t5_wen",   32'(rf_wen), 32'd0);
        check("t5_busy",  32'(busy1),  32'd0);

        // Forwarding
        drain_en = 1'b0;
        rsel1 = 5'd10;
        rsel2 = 5'd9;
        push(5'd9,  32'h100);
        push(5'd9,  32'h200);
        push(5'd10, 32'h300);
        check("t6_busy2", 32'(busy2), 32'd1);
`ifdef REGFILE_WQ_FWD_EN
        check("t6_fwd2_valid", 32'(fwd2_valid), 32'd1);
        check("t6_fwd2_dat",   fwd2_dat,        32'h200);
        check("t6_fwd1_dat",   fwd1_dat,        32'h300);
`else
        check("t6_fwd2_valid", 32'(fwd2_valid), 32'd0);
        check("t6_fwd2_dat",   fwd2_dat,        32'h0);
        check("t6_fwd1_dat",   fwd1_dat,        32'h0);
`endif
        drain_en = 1'b1;
        tick();
        check("t6_wsel_last9", 32'(rf_wsel), 32'd9);
`ifdef REGFILE_WQ_FWD_EN
        check("t6_fwd_popping", fwd2_dat, 32'h200);
`else
        check("t6_fwd_popping", fwd2_dat, 32'h0);
`endif
        tick();
        check("t6_fwd2_gone",  32'(fwd2_valid), 32'd0);
        check("t6_busy2_gone", 32'(busy2),      32'd0);
        check("t6_wsel_10",    32'(rf_wsel),    32'd10);
        tick();
        check("t6_empty", 32'(count), 32'd0);
        drain_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_write_queue.md
Name: regfile_write_queue

Overview:
- Writer-side front end for the CPU's 32x32 register file.
- Buffers register write requests from the execution/memory stages in an in-order FIFO and drains one per cycle onto the register file write port (wen/wsel/wdat).
- Keeps a per-register pending-write scoreboard so decode can detect RAW hazards on its read selects.

Parameters:
DEPTH, 4, FIFO entries; power of two, 2..16.
CNT_W, $clog2(DEPTH+1), width of each per-register pending counter (derived, not overridden).

Ports:
CLK  input  1  clock; all state updates on posedge.
RST  input  1  reset, asynchronous, active-high.
req_valid  input  1  write request present.
req_ready  output  1  queue can accept; equals !full.
req_sel  input  5  destination register.
req_dat  input  32  write data.
drain_en  input  1  permit pop this cycle; 0 holds the queue (e.g. while a register file writeback is blocked).
rf_wen  output  1  register file write enable.
rf_wsel  output  5  register file write select.
rf_wdat  output  32  register file write data.
rsel1  input  5  decode read select 1.
rsel2  input  5  decode read select 2.
busy1  output  1  rsel1 has at least one queued write.
busy2  output  1  rsel2 has at least one queued write.
fwd1_valid  output  1  forwarding hit for rsel1 (optional feature).
fwd1_dat  output  32  forwarded data for rsel1 (optional feature).
fwd2_valid  output  1  forwarding hit for rsel2 (optional feature).
fwd2_dat  output  32  forwarded data for rsel2 (optional feature).
count  output  CNT_W  current occupancy.

Behaviour:
- Clock and reset: one clock, CLK. RST is asynchronous, active-high. While RST=1:
  - head/tail pointers, occupancy and all 32 pending counters clear to 0.
  - outputs: rf_wen=0, rf_wsel=0, rf_wdat=0, busy*=0, fwd*=0, count=0, req_ready=1.
  - Reset mid-drain discards all queued entries; no partial write is issued.
- Accept: handshake is req_valid && req_ready at posedge.
  - If req_sel!=0, the {sel,dat} entry is written at tail and tail advances (mod DEPTH).
  - If req_sel==0, the request is accepted but dropped: nothing is enqueued and no counter changes.
- Drain (combinational from head):
  - rf_wen = !empty && drain_en; rf_wsel/rf_wdat = head entry when rf_wen=1, else 0.
  - On posedge with rf_wen=1, head advances.
  - The register file commits on the falling edge of the same cycle.
- Latency: an entry accepted at edge N drives rf_wen at the earliest in the cycle after edge N. There is no empty-queue bypass.
- Full: req_ready=0. There is no same-cycle pop-frees-slot bypass, so req_ready never depends on drain_en.
- Empty: rf_wen=0 regardless of drain_en.
- Simultaneous push and pop: allowed whenever !full && !empty.
  - Occupancy is unchanged.
  - If push sel == pop sel, that register's counter is unchanged.
- Scoreboard:
  - cnt[r] increments on accepted non-zero push to r and decrements on pop of r.
  - cnt[r] never exceeds DEPTH.
  - busyN = (rselN!=0) && cnt[rselN]!=0, combinational.
  - cnt[0] is always 0.
- Pointers: the wrap-around of head/tail is by modulo DEPTH. Full/empty are derived from a separate occupancy counter (0..DEPTH).

Optional Feature:
- Macro REGFILE_WQ_FWD_EN.
- Defined:
  - fwdN_valid = busyN.
  - fwdN_dat = data of the youngest queued entry whose sel==rselN; this is found by a combinational priority search from tail-1 back to head.
  - An entry being popped this cycle is still visible to forwarding.
- Undefined: fwd ports remain present but are tied to 0, and no search logic is built.

Decomposition:
- cpu_types_pkg provides:
  - word_t (32b).
  - regbits_t (5b).
  - wq_entry_t, a packed struct {regbits_t sel; word_t dat;}.
  - constant WQ_DEPTH_DEFAULT = 4.
- One natural sub-module, wq_fifo: a parameterised storage/pointer/occupancy FIFO of wq_entry_t.
- Scoreboard and forwarding stay in the top level.

Test Plan:
1. Reset mid-drain: push r3=0x11 and r4=0x22, assert RST for 1 cycle -> count=0, busy1 (rsel1=3)=0, rf_wen=0, req_ready=1.
2. Basic ordering: drain_en=0; push r5=0xA, r6=0xB; then drain_en=1 -> rf_wen on 2 consecutive cycles with (5,0xA) then (6,0xB), then rf_wen=0.
3. Full: DEPTH=4, drain_en=0, push 4 entries -> req_ready=0, a 5th req_valid is not accepted, count=4. Drain one -> req_ready=1 next cycle.
4. Scoreboard duplicates: push r7=1, r7=2 -> cnt=2, busy1=1 (rsel1=7). After the first pop busy1=1; after the second pop busy1=0. Simultaneous push r7 and pop r7 keeps cnt unchanged.
5. Zero register: push r0=0xFFFF -> accepted (req_ready stays 1), count stays 0, no rf_wen, busy for rsel=0 stays 0.
6. With REGFILE_WQ_FWD_EN: queue r9=0x100, r9=0x200, rsel2=9 -> fwd2_valid=1, fwd2_dat=0x200. After both pops, fwd2_valid=0. Without the macro, fwd2_valid=0 throughout.
